aes_block_packer: RTL and testbench
===================================

// Module: aes_block_packer
// PURPOSE
//  Upstream feeder for the AES encrypt core. Collects a byte stream (e.g. an ASCII message such as "Hello!")
//  into 128-bit plaintext blocks and applies PKCS#7 padding to the final block.
//  Presents each block on a valid/ready interface that drives the cipher's 128-bit plaintext input.
//  Byte 0 of each block is placed in [127:120], which matches the Verilog string-literal packing order.
// PARAMETERS
//  PKCS7_FULL_BLOCK  1  1: a message ending exactly on a 16-byte boundary gets an extra block of 16 x 8'h10.
//                       0: no extra block is emitted for such a message.
// PORTS
//  clk            in   1    rising-edge clock
//  rst            in   1    asynchronous, active-high reset
//  in_data        in   8    message byte
//  in_valid       in   1    in_data is valid
//  in_last        in   1    this byte is the final byte of the message (qualified by in_valid)
//  in_ready       out  1    block can accept a byte this cycle
//  out_block      out  128  packed, padded block; byte i occupies [127-8i -: 8]
//  out_valid      out  1    out_block is valid
//  out_ready      in   1    consumer accepts out_block
//  out_last       out  1    out_block is the final block of the message
//  out_nbytes     out  5    number of message bytes in out_block (0..16); the rest is padding
// BEHAVIOUR
//  - Reset: asynchronous and active-high. While rst is high all outputs go to 0 immediately: in_ready=0,
//    out_valid=0, out_block=0, out_last=0, out_nbytes=0. Internal count=0, state=FILL, pend=0.
//    in_ready is 1 from the first clock edge after rst deasserts.
//    Reset during a partial block or a held output discards that data with no output.
//  - Byte transfer when in_valid && in_ready. Block transfer when out_valid && out_ready.
//  - States: FILL and EMIT.
//  - FILL: in_ready=1, out_valid=0. Accepting a byte at index k=count writes byte k of the block register
//    and increments count.
//    - Last byte (in_last=1), k<15: in the same edge, write bytes k+1..15 with pad value (15-k).
//      Set out_nbytes=k+1 and out_last=1, then go to EMIT.
//    - k==15, in_last=0: set out_nbytes=16 and out_last=0, then go to EMIT.
//    - k==15, in_last=1, PKCS7_FULL_BLOCK=1: set out_nbytes=16, out_last=0 and pend=1, then go to EMIT.
//    - k==15, in_last=1, PKCS7_FULL_BLOCK=0: set out_nbytes=16 and out_last=1, then go to EMIT.
//  - EMIT: out_valid=1, in_ready=0.
//    - out_block, out_last and out_nbytes stay stable until the block transfer.
//    - On transfer with pend=1: load 16 x 8'h10, out_nbytes=0, out_last=1, clear pend, stay in EMIT.
//    - On transfer with pend=0: count=0, go to FILL (out_valid=0 next cycle).
//  - Latency: out_valid rises on the edge that accepts the completing byte.
//    Throughput is 16 bytes plus 1 bubble cycle per block.
//  - Gaps in in_valid are allowed anywhere; count holds across gaps.
//  - Empty messages cannot be expressed: every message has at least one byte.
//  - in_last is ignored when in_valid=0. Changes to in_data while in_ready=0 have no effect.
//  - out_block bytes at indices >= count while in FILL are don't-care; they are never visible with out_valid=1.
// TESTING
//  1. Send "Hello!" as 6 bytes, in_last on 8'h21.
//     -> one block 128'h48656C6C6F21_0A0A0A0A0A0A0A0A0A0A, nbytes=6, last=1.
//  2. Send 8'h00..8'h0F, in_last on 8'h0F, PKCS7_FULL_BLOCK=1.
//     -> block 128'h000102..0F (nbytes=16, last=0), then 128'h1010..10 (nbytes=0, last=1).
//     With PKCS7_FULL_BLOCK=0: a single block with last=1.
//  3. Send a 20-byte message A0..B3, last on B3.
//     -> block A0..AF (last=0); then B0 B1 B2 B3 followed by 12 x 8'h0C (nbytes=4, last=1).
//  4. Hold out_ready=0 for 5 cycles during EMIT.
//     -> out_block and out_nbytes stable, in_ready=0, and the next message's bytes are not lost once ready rises.
//  5. Single byte 8'h6B with in_last=1, injecting 3 idle cycles before it.
//     -> 128'h6B0F0F...0F, nbytes=1.
//  6. Assert rst asynchronously (mid-cycle) after 5 of "Hello!".
//     -> outputs 0 at once. After release, case 1 replays cleanly with no stale bytes.

Source files
------------

// File: rtl/aes_block_packer.sv
// Packs a byte stream into 128-bit AES plaintext blocks with PKCS#7 padding on the final block.
// Byte 0 of each block sits in [127:120]; blocks leave on a valid/ready handshake.
module aes_block_packer #(
  parameter bit PKCS7_FULL_BLOCK = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [127:0] out_block,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic [4:0]   out_nbytes
);

  typedef enum logic {
    FILL = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t         r_state, w_state_nx;
  logic           r_run;
  logic [3:0]     r_count, w_count_nx;
  logic [127:0]   r_block, w_block_nx;
  logic [4:0]     r_nbytes, w_nbytes_nx;
  logic           r_last, w_last_nx;
  logic           r_pend, w_pend_nx;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nx  = r_state;
    w_count_nx  = r_count;
    w_block_nx  = r_block;
    w_nbytes_nx = r_nbytes;
    w_last_nx   = r_last;
    w_pend_nx   = r_pend;
    in_ready    = 1'b0;
    out_valid   = 1'b0;

    case (r_state)
      FILL: begin
        in_ready = r_run;
        if (in_valid && r_run) begin
          // Store the byte at index count; on the last byte pad everything after it.
          for (int i = 0; i < 16; i++) begin
            if (4'(i) == r_count)
              w_block_nx[127-8*i -: 8] = in_data;
            else if (in_last && (4'(i) > r_count))
              w_block_nx[127-8*i -: 8] = 8'd15 - {4'd0, r_count};
          end
          w_count_nx = r_count + 4'd1;
          if (in_last || (r_count == 4'd15)) begin
            w_state_nx  = EMIT;
            w_nbytes_nx = {1'b0, r_count} + 5'd1;
            w_pend_nx   = in_last && (r_count == 4'd15) && PKCS7_FULL_BLOCK;
            w_last_nx   = in_last && !(r_count == 4'd15 && PKCS7_FULL_BLOCK);
          end
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (r_pend) begin
            w_block_nx  = {16{8'h10}};
            w_nbytes_nx = 5'd0;
            w_last_nx   = 1'b1;
            w_pend_nx   = 1'b0;
          end else begin
            w_state_nx = FILL;
            w_count_nx = 4'd0;
          end
        end
      end
      default: w_state_nx = FILL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  // NOTE: the block register is reset because out_block must read 0 while rst is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= FILL;
      r_run    <= 1'b0;
      r_count  <= 4'd0;
      r_block  <= '0;
      r_nbytes <= 5'd0;
      r_last   <= 1'b0;
      r_pend   <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_run    <= 1'b1;
      r_count  <= w_count_nx;
      r_block  <= w_block_nx;
      r_nbytes <= w_nbytes_nx;
      r_last   <= w_last_nx;
      r_pend   <= w_pend_nx;
    end
  end

  assign out_block  = r_block;
  assign out_last   = r_last;
  assign out_nbytes = r_nbytes;

endmodule

// File: tb/tb_aes_block_packer.sv
// Scoreboard bench for aes_block_packer: dut0 uses the full-block pad block, dut1 does not.
module tb_aes_block_packer;

  typedef struct {
    logic [127:0] blk;
    logic [4:0]   nb;
    logic         last;
  } exp_t;

  logic         clk;
  logic         rst;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_last;
  logic         out_ready;

  logic         in_ready, out_valid, out_last;
  logic [127:0] out_block;
  logic [4:0]   out_nbytes;

  logic         in_ready1, out_valid1, out_last1;
  logic [127:0] out_block1;
  logic [4:0]   out_nbytes1;
  logic         w_valid1;

  exp_t exp0[$];
  exp_t exp1[$];
  exp_t m0_e, m1_e;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] HELLO_BLK = 128'h48656C6C6F21_0A0A0A0A0A0A0A0A0A0A;
  localparam logic [127:0] HI_BLK    = 128'h4869_0E0E0E0E0E0E0E0E0E0E0E0E0E0E;

  aes_block_packer #(.PKCS7_FULL_BLOCK(1'b1)) dut0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_block(out_block), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .out_nbytes(out_nbytes)
  );

  // dut1 only sees bytes that dut0 accepts, so both track the same message stream.
  assign w_valid1 = in_valid & in_ready;

  aes_block_packer #(.PKCS7_FULL_BLOCK(1'b0)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(w_valid1), .in_last(in_last),
    .in_ready(in_ready1), .out_block(out_block1), .out_valid(out_valid1),
    .out_ready(1'b1), .out_last(out_last1), .out_nbytes(out_nbytes1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_both(input logic [127:0] b, input logic [4:0] nb, input logic l);
    exp_t e;
    e.blk = b; e.nb = nb; e.last = l;
    exp0.push_back(e);
    exp1.push_back(e);
  endtask

  task automatic push0(input logic [127:0] b, input logic [4:0] nb, input logic l);
    exp_t e;
    e.blk = b; e.nb = nb; e.last = l;
    exp0.push_back(e);
  endtask

  task automatic push1(input logic [127:0] b, input logic [4:0] nb, input logic l);
    exp_t e;
    e.blk = b; e.nb = nb; e.last = l;
    exp1.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 just after the byte was accepted.
  task automatic send_byte(input logic [7:0] d, input logic l);
    int n = 0;
    in_data  = d;
    in_valid = 1'b1;
    in_last  = l;
    while (!in_ready && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stuck at 0 for byte %h", d);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp0.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut0_unexpected: got block %h expected no block", out_block);
      end else begin
        m0_e = exp0.pop_front();
        check("dut0_block", out_block, m0_e.blk);
        check("dut0_nbytes", 128'(out_nbytes), 128'(m0_e.nb));
        check("dut0_last", 128'(out_last), 128'(m0_e.last));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid1) begin
      if (exp1.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut1_unexpected: got block %h expected no block", out_block1);
      end else begin
        m1_e = exp1.pop_front();
        check("dut1_block", out_block1, m1_e.blk);
        check("dut1_nbytes", 128'(out_nbytes1), 128'(m1_e.nb));
        check("dut1_last", 128'(out_last1), 128'(m1_e.last));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] hello [6];
    hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h21};

    clk = 1'b0; rst = 1'b1;
    in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;

    // Reset state
    #2;
    check("rst_in_ready", 128'(in_ready), 128'd0);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_out_block", out_block, 128'd0);
    check("rst_out_nbytes", 128'(out_nbytes), 128'd0);
    check("rst_out_last", 128'(out_last), 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("in_ready_before_edge", 128'(in_ready), 128'd0);
    @(posedge clk); #1;
    check("in_ready_after_edge", 128'(in_ready), 128'd1);

    // 1: "Hello!"
    push_both(HELLO_BLK, 5'd6, 1'b1);
    for (int i = 0; i < 6; i++) send_byte(hello[i], i == 5);
    idle(2);

    // 2: exactly 16 bytes, full-block padding differs between the two instances
    push0(128'h000102030405060708090A0B0C0D0E0F, 5'd16, 1'b0);
    push0({16{8'h10}}, 5'd0, 1'b1);
    push1(128'h000102030405060708090A0B0C0D0E0F, 5'd16, 1'b1);
    for (int i = 0; i < 16; i++) send_byte(8'(i), i == 15);
    idle(2);

    // 3: 20-byte message spanning two blocks
    push_both(128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF, 5'd16, 1'b0);
    push_both(128'hB0B1B2B3_0C0C0C0C0C0C0C0C0C0C0C0C, 5'd4, 1'b1);
    for (int i = 0; i < 20; i++) send_byte(8'hA0 + 8'(i), i == 19);
    idle(2);

    // 4: back-pressure for 5 cycles with the next message's byte already offered
    push_both(HI_BLK, 5'd2, 1'b1);
    push_both(128'h55_0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F, 5'd1, 1'b1);
    out_ready = 1'b0;
    send_byte(8'h48, 1'b0);
    send_byte(8'h69, 1'b1);
    in_data  = 8'h55;
    in_valid = 1'b1;
    in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check("stall_out_valid", 128'(out_valid), 128'd1);
      check("stall_in_ready", 128'(in_ready), 128'd0);
      check("stall_block", out_block, HI_BLK);
      check("stall_nbytes", 128'(out_nbytes), 128'd2);
      @(posedge clk); #1;
      in_data = 8'hEE ^ 8'(c);
    end
    out_ready = 1'b1;
    send_byte(8'h55, 1'b1);

    // 5: single byte after idle cycles
    idle(3);
    push_both(128'h6B_0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F, 5'd1, 1'b1);
    send_byte(8'h6B, 1'b1);
    idle(3);

    // 6: asynchronous reset mid-cycle after 5 bytes of "Hello!"
    for (int i = 0; i < 5; i++) send_byte(hello[i], 1'b0);
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 128'(in_ready), 128'd0);
    check("mid_rst_out_valid", 128'(out_valid), 128'd0);
    check("mid_rst_out_block", out_block, 128'd0);
    check("mid_rst_out_nbytes", 128'(out_nbytes), 128'd0);
    check("mid_rst_out_last", 128'(out_last), 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    push_both(HELLO_BLK, 5'd6, 1'b1);
    for (int i = 0; i < 6; i++) send_byte(hello[i], i == 5);

    for (int i = 0; i < 100 && (exp0.size() != 0 || exp1.size() != 0); i++) begin
      @(posedge clk); #1;
    end
    check("dut0_queue_drained", 128'(exp0.size()), 128'd0);
    check("dut1_queue_drained", 128'(exp1.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
